// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// The controller and the datapath both import this package.
package muldiv_sequencer_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   function automatic logic is_muldiv(input op_e op);
      return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side request/response bundle of the HI/LO sequencer.
// The master drives the request; the slave returns HI/LO and the status bits.
interface muldiv_sequencer_if #(parameter int DATA_W = 32);
   import muldiv_sequencer_pkg::*;

   logic              Start;
   op_e               Op;
   logic [DATA_W-1:0] OpA;
   logic [DATA_W-1:0] OpB;
   logic              Abort;
   logic [DATA_W-1:0] HI;
   logic [DATA_W-1:0] LO;
   logic [DATA_W-1:0] ReadData;
   logic              Busy;
   logic              Stall;
   logic              Done;

   modport master (
      output Start, Op, OpA, OpB, Abort,
      input  HI, LO, ReadData, Busy, Stall, Done
   );

   modport slave (
      input  Start, Op, OpA, OpB, Abort,
      output HI, LO, ReadData, Busy, Stall, Done
   );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation, either of two independent words
// or of the pair {a,b} treated as one double-width value.
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         neg_a,
   input  logic         neg_b,
   input  logic         wide,
   output logic [W-1:0] a_out,
   output logic [W-1:0] b_out
);
   logic [2*W-1:0] wide_val;

   always_comb begin
      wide_val = neg_a ? -{a, b} : {a, b};
      if (wide) begin
         a_out = wide_val[2*W-1:W];
         b_out = wide_val[W-1:0];
      end else begin
         a_out = neg_a ? -a : a;
         b_out = neg_b ? -b : b;
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per RUN cycle, sign correction in FIX.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input logic               Clk,
   input logic               Reset,
   muldiv_sequencer_if.slave bus
);
   state_e            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] hi_reg, lo_reg;
   logic [DATA_W-1:0] rem_reg, quo_reg, mag_reg;
   logic              neg_hi_reg, neg_lo_reg, is_div_reg, done_reg;

   logic              idle, accept, op_signed, op_div, div_by_zero, last_step, prod_neg;
   logic [DATA_W-1:0] a_abs, b_abs, fix_hi, fix_lo;
   logic [DATA_W:0]   mul_sum, div_shift, div_diff;

   assign idle        = (state == ST_IDLE);
   assign op_signed   = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
   assign op_div      = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
   assign div_by_zero = op_div && (bus.OpB == '0);
   assign accept      = idle && bus.Start && !bus.Abort && is_muldiv(bus.Op);
   assign last_step   = (cnt == CNT_W'(DATA_W - 1));
   assign prod_neg    = op_signed && (bus.OpA[DATA_W-1] ^ bus.OpB[DATA_W-1]);

   muldiv_sign_fix #(.W(DATA_W)) u_entry_fix (
      .a     (bus.OpA),
      .b     (bus.OpB),
      .neg_a (op_signed && bus.OpA[DATA_W-1]),
      .neg_b (op_signed && bus.OpB[DATA_W-1]),
      .wide  (1'b0),
      .a_out (a_abs),
      .b_out (b_abs)
   );

   // Multiply keeps the product in {rem,quo}, so it is negated as one wide value.
   muldiv_sign_fix #(.W(DATA_W)) u_result_fix (
      .a     (rem_reg),
      .b     (quo_reg),
      .neg_a (neg_hi_reg),
      .neg_b (neg_lo_reg),
      .wide  (!is_div_reg),
      .a_out (fix_hi),
      .b_out (fix_lo)
   );

   assign mul_sum   = {1'b0, rem_reg} + (quo_reg[0] ? {1'b0, mag_reg} : '0);
   assign div_shift = {rem_reg, quo_reg[DATA_W-1]};
   assign div_diff  = div_shift - {1'b0, mag_reg};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (accept) state_next = div_by_zero ? ST_FIX : ST_RUN;
         ST_RUN:  if (bus.Abort) state_next = ST_IDLE;
                  else if (last_step) state_next = ST_FIX;
         ST_FIX:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.Busy  = !idle;
      bus.Stall = bus.Start && !idle;
      bus.Done  = done_reg;
      bus.HI    = hi_reg;
      bus.LO    = lo_reg;
      case (bus.Op)
         OP_MFHI: bus.ReadData = hi_reg;
         OP_MFLO: bus.ReadData = lo_reg;
         default: bus.ReadData = '0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt        <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         mag_reg    <= '0;
         neg_hi_reg <= 1'b0;
         neg_lo_reg <= 1'b0;
         is_div_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  cnt        <= '0;
                  is_div_reg <= op_div;
                  rem_reg    <= '0;
                  if (div_by_zero) begin
                     // Raw dividend and all-ones pass through FIX uncorrected.
                     rem_reg    <= bus.OpA;
                     quo_reg    <= '1;
                     mag_reg    <= '0;
                     neg_hi_reg <= 1'b0;
                     neg_lo_reg <= 1'b0;
                  end else if (op_div) begin
                     quo_reg    <= a_abs;
                     mag_reg    <= b_abs;
                     neg_hi_reg <= op_signed && bus.OpA[DATA_W-1];
                     neg_lo_reg <= prod_neg;
                  end else begin
                     quo_reg    <= b_abs;
                     mag_reg    <= a_abs;
                     neg_hi_reg <= prod_neg;
                     neg_lo_reg <= prod_neg;
                  end
               end else if (bus.Start && !bus.Abort && bus.Op == OP_MTHI) begin
                  hi_reg <= bus.OpA;
               end else if (bus.Start && !bus.Abort && bus.Op == OP_MTLO) begin
                  lo_reg <= bus.OpA;
               end
            end
            ST_RUN: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div_reg) begin
                  if (!div_diff[DATA_W]) begin
                     rem_reg <= div_diff[DATA_W-1:0];
                     quo_reg <= {quo_reg[DATA_W-2:0], 1'b1};
                  end else begin
                     rem_reg <= div_shift[DATA_W-1:0];
                     quo_reg <= {quo_reg[DATA_W-2:0], 1'b0};
                  end
               end else begin
                  rem_reg <= mul_sum[DATA_W:1];
                  quo_reg <= {mul_sum[0], quo_reg[DATA_W-1:1]};
               end
            end
            ST_FIX: begin
               if (!bus.Abort) begin
                  hi_reg   <= fix_hi;
                  lo_reg   <= fix_lo;
                  done_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences and random operations against an arithmetic reference model.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   localparam int DW = 32;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   muldiv_sequencer_if #(.DATA_W(DW)) bus();

   muldiv_sequencer #(.DATA_W(DW), .CNT_W(6)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   typedef struct {
      op_e         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
   function automatic void model(input op_e op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = '0;
      lo = '0;
      case (op)
         OP_MULT: begin
            p = 64'(sa * sb);
            hi = p[63:32]; lo = p[31:0];
         end
         OP_MULTU: begin
            p = {32'b0, a} * {32'b0, b};
            hi = p[63:32]; lo = p[31:0];
         end
         OP_DIV: begin
            if (b == 0) begin hi = a; lo = '1; end
            else begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; hi = r[31:0];
            end
         end
         OP_DIVU: begin
            if (b == 0) begin hi = a; lo = '1; end
            else begin lo = a / b; hi = a % b; end
         end
         default: ;
      endcase
   endfunction

   // Issues one accepted op from IDLE and waits (bounded) for Done.
   task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output logic done_after);
      logic seen;
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = op; bus.OpA = a; bus.OpB = b;
      lat = 0; seen = 1'b0;
      while (lat < 100 && !seen) begin
         @(negedge Clk);
         bus.Start = 1'b0;
         lat++;
         if (bus.Done) seen = 1'b1;
      end
      if (!seen) lat = -1;
      hi = bus.HI; lo = bus.LO;
      @(negedge Clk);
      done_after = bus.Done;
   endtask

   vec_t vecs[10];

   initial begin
      int          lat, cnt_done, k, last_stall;
      logic [31:0] hi, lo, ehi, elo, hi0, lo0, ra, rb;
      logic        dafter;
      op_e         rop;

      bus.Start = 1'b0; bus.Op = OP_MULT; bus.OpA = '0; bus.OpB = '0; bus.Abort = 1'b0;

      vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 34};
      vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
      vecs[3] = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 2};
      vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
      vecs[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
      vecs[6] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34};
      vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
      vecs[8] = '{OP_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 2};
      vecs[9] = '{OP_MULTU, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 34};

      // Reset state
      repeat (3) @(negedge Clk);
      check("reset_hi", bus.HI, 0);
      check("reset_lo", bus.LO, 0);
      check("reset_busy", bus.Busy, 0);
      check("reset_done", bus.Done, 0);
      bus.Start = 1'b1; bus.Op = OP_MFHI;
      #1 check("reset_stall", bus.Stall, 0);
      bus.Start = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo, dafter);
         $display("vec %0d %s a=%h b=%h -> hi=%h lo=%h lat=%0d", i, vecs[i].op.name(),
                  vecs[i].a, vecs[i].b, hi, lo, lat);
         check("vec_hi", hi, vecs[i].hi);
         check("vec_lo", lo, vecs[i].lo);
         check("vec_lat", lat, vecs[i].lat);
         check("vec_done_pulse", dafter, 0);
      end

      // MTLO / MFLO / MFHI moves
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_MTLO; bus.OpA = 32'hCAFEBABE;
      @(negedge Clk);
      bus.Start = 1'b0;
      $display("move MTLO 0xcafebabe -> lo=%h busy=%b done=%b", bus.LO, bus.Busy, bus.Done);
      check("mtlo_lo", bus.LO, 32'hCAFEBABE);
      check("mtlo_busy", bus.Busy, 0);
      check("mtlo_done", bus.Done, 0);
      bus.Start = 1'b1; bus.Op = OP_MFLO;
      #1 check("mflo_read", bus.ReadData, 32'hCAFEBABE);
      bus.Op = OP_MFHI;
      #1 check("mfhi_read", bus.ReadData, 32'h00000000);
      bus.Start = 1'b0;

      // MFLO presented 5 cycles into a MULT: stalls through FIX, then reads the new LO
      model(OP_MULT, 32'h00012345, 32'hFFFF0003, ehi, elo);
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_MULT; bus.OpA = 32'h00012345; bus.OpB = 32'hFFFF0003;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (4) @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_MFLO;
      k = 5; last_stall = -1;
      while (k < 100) begin
         #1;
         if (!bus.Stall) break;
         last_stall = k;
         @(negedge Clk);
         k++;
      end
      $display("stall MFLO after MULT: released at cycle %0d readdata=%h", k, bus.ReadData);
      check("stall_release_cycle", k, 34);
      check("stall_in_fix", last_stall, 33);
      check("stall_readdata", bus.ReadData, elo);
      check("stall_done", bus.Done, 1);
      bus.Start = 1'b0;

      // Abort at RUN cycle 10 of a DIV
      hi0 = bus.HI; lo0 = bus.LO;
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_DIV; bus.OpA = 32'hFFFFFF9C; bus.OpB = 32'd3;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (9) @(negedge Clk);
      bus.Abort = 1'b1;
      @(negedge Clk);
      bus.Abort = 1'b0;
      $display("abort DIV at run 10 -> busy=%b hi=%h lo=%h", bus.Busy, bus.HI, bus.LO);
      check("abort_busy", bus.Busy, 0);
      check("abort_hi", bus.HI, hi0);
      check("abort_lo", bus.LO, lo0);
      cnt_done = 0;
      repeat (40) begin @(negedge Clk); if (bus.Done) cnt_done++; end
      check("abort_no_done", cnt_done, 0);

      // Abort in the FIX cycle of a divide-by-zero
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OpA = 32'h55555555; bus.OpB = '0;
      @(negedge Clk);
      bus.Start = 1'b0; bus.Abort = 1'b1;
      @(negedge Clk);
      bus.Abort = 1'b0;
      $display("abort in FIX -> done=%b hi=%h lo=%h", bus.Done, bus.HI, bus.LO);
      check("abort_fix_done", bus.Done, 0);
      check("abort_fix_hi", bus.HI, hi0);
      check("abort_fix_busy", bus.Busy, 0);

      // Abort beats a simultaneous Start in IDLE
      bus.Start = 1'b1; bus.Op = OP_MULT; bus.OpA = 32'd5; bus.OpB = 32'd5; bus.Abort = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0; bus.Abort = 1'b0;
      $display("abort with start -> busy=%b", bus.Busy);
      check("abort_start_busy", bus.Busy, 0);

      // Reset mid-RUN, then MTHI in the first cycle after release
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_MULT; bus.OpA = 32'h00000123; bus.OpB = 32'h00000456;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (9) @(negedge Clk);
      Reset = 1'b1;
      #1;
      $display("reset mid-run -> hi=%h lo=%h busy=%b", bus.HI, bus.LO, bus.Busy);
      check("midreset_hi", bus.HI, 0);
      check("midreset_lo", bus.LO, 0);
      check("midreset_busy", bus.Busy, 0);
      @(negedge Clk);
      Reset = 1'b0;
      bus.Start = 1'b1; bus.Op = OP_MTHI; bus.OpA = 32'h00001234;
      @(negedge Clk);
      bus.Start = 1'b0;
      $display("MTHI after reset -> hi=%h busy=%b", bus.HI, bus.Busy);
      check("postreset_mthi", bus.HI, 32'h00001234);
      check("postreset_busy", bus.Busy, 0);
      cnt_done = 0;
      repeat (40) begin @(negedge Clk); if (bus.Done) cnt_done++; end
      check("postreset_no_done", cnt_done, 0);
      check("postreset_lo", bus.LO, 0);

      // Random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rop = op_e'($urandom_range(0, 3));
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 5));
            2: begin ra = 32'h80000000; rb = '1; end
            default: ;
         endcase
         model(rop, ra, rb, ehi, elo);
         run_op(rop, ra, rb, lat, hi, lo, dafter);
         $display("rand %0d %s a=%h b=%h -> hi=%h lo=%h lat=%0d", i, rop.name(), ra, rb, hi, lo, lat);
         check("rand_hi", hi, ehi);
         check("rand_lo", lo, elo);
         check("rand_lat", lat, ((rop == OP_DIV || rop == OP_DIVU) && rb == 0) ? 2 : 34);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
